// File: rtl/crc_frame_engine_if.sv
// Beat and result signals between the link framer and the CRC frame engine.
// The framer side drives beats; the engine side returns results and status.
interface crc_frame_engine_if #(
    parameter int CRC_W  = 16,
    parameter int DATA_W = 16
);
    logic                  crc_sop;
    logic                  crc_eop;
    logic                  crc_din_vld;
    logic [DATA_W-1:0]     crc_din;
    logic [DATA_W/8-1:0]   crc_be;
    logic                  crc_chk_en;
    logic [CRC_W-1:0]      crc_ref;
    logic [CRC_W-1:0]      crc_dout;
    logic                  crc_done;
    logic                  crc_err;
    logic                  crc_busy;
    logic                  crc_seq_err;

    modport master (
        output crc_sop, crc_eop, crc_din_vld, crc_din, crc_be, crc_chk_en, crc_ref,
        input  crc_dout, crc_done, crc_err, crc_busy, crc_seq_err
    );

    modport slave (
        input  crc_sop, crc_eop, crc_din_vld, crc_din, crc_be, crc_chk_en, crc_ref,
        output crc_dout, crc_done, crc_err, crc_busy, crc_seq_err
    );
endinterface

// File: rtl/crc_frame_engine.sv
// Frame-aware reflected CRC engine: one beat per cycle, unrolled across all byte lanes,
// with frame sequencing checks and optional compare against a received CRC.
module crc_frame_engine #(
    parameter int               CRC_W  = 16,
    parameter int               DATA_W = 16,
    parameter logic [CRC_W-1:0] POLY   = 16'h1021,
    parameter logic [CRC_W-1:0] INIT   = 16'hFFFF,
    parameter logic [CRC_W-1:0] XOROUT = 16'h0000
) (
    input  logic                 clk_sys,
    input  logic                 rst_sys,
    crc_frame_engine_if.slave    link
);
    localparam int LANES = DATA_W / 8;

    function automatic logic [CRC_W-1:0] reflect(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = v[CRC_W-1-i];
        end
        return r;
    endfunction

    localparam logic [CRC_W-1:0] POLY_REF = reflect(POLY);

    // Bytes enter lane 0 first, each byte LSB-first through the right-shifting LFSR.
    function automatic logic [CRC_W-1:0] crc_update(
        input logic [CRC_W-1:0]  seed,
        input logic [DATA_W-1:0] data,
        input logic [LANES-1:0]  mask
    );
        logic [CRC_W-1:0] c;
        logic             fb;
        c = seed;
        for (int k = 0; k < LANES; k++) begin
            if (mask[k]) begin
                for (int b = 0; b < 8; b++) begin
                    fb = c[0] ^ data[8*k + b];
                    c  = c >> 1;
                    if (fb) c = c ^ POLY_REF;
                end
            end
        end
        return c;
    endfunction

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [CRC_W-1:0]   crc_reg;
    logic [CRC_W-1:0]   dout_q;
    logic               done_q;
    logic               err_q;
    logic               busy_q;
    logic               seq_err_q;

    logic [LANES-1:0]   lane_mask;
    logic               run;
    logic               be_err;
    logic [CRC_W-1:0]   seed;
    logic [CRC_W-1:0]   beat_crc;
    logic [CRC_W-1:0]   final_crc;

    // Only the contiguous run of lanes from lane 0 counts on an eop beat; earlier beats are always full.
    always_comb begin
        run       = 1'b1;
        lane_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            run          = run & link.crc_be[k];
            lane_mask[k] = run;
        end
        if (link.crc_eop) begin
            be_err = (link.crc_be != lane_mask) || (lane_mask == '0);
        end else begin
            be_err    = (link.crc_be != '1);
            lane_mask = '1;
        end
        seed      = link.crc_sop ? INIT : crc_reg;
        beat_crc  = crc_update(seed, link.crc_din, lane_mask);
        final_crc = beat_crc ^ XOROUT;
    end

    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            state     <= IDLE;
            crc_reg   <= INIT;
            dout_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            seq_err_q <= 1'b0;
            if (link.crc_din_vld) begin
                seq_err_q <= be_err || (state == IDLE && !link.crc_sop)
                                    || (state == RUN && link.crc_sop);
                // A sop always restarts from INIT, abandoning any frame in flight.
                if (link.crc_sop || state == RUN) begin
                    if (link.crc_eop) begin
                        dout_q  <= final_crc;
                        err_q   <= link.crc_chk_en && (final_crc != link.crc_ref);
                        done_q  <= 1'b1;
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        crc_reg <= INIT;
                    end else begin
                        crc_reg <= beat_crc;
                        state   <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
            end
        end
    end

    assign link.crc_dout    = dout_q;
    assign link.crc_done    = done_q;
    assign link.crc_err     = err_q;
    assign link.crc_busy    = busy_q;
    assign link.crc_seq_err = seq_err_q;
endmodule

// File: doc/crc_frame_engine.md
# crc_frame_engine

Parametrised, frame-aware CRC engine, successor to the fixed 16-bit CRC-16 calculator used on the inter-board links. Width, polynomial, init and final XOR are parameters, and input beats may be any whole number of bytes wide. Partial last beats, frame sequencing with error flags and an optional in-line compare against a received CRC are built in. It sits between the link framer and the frame checker on both the TX path (generate) and the RX path (check).

## Interface
- CRC_W, 16, CRC register width (8..32)
- DATA_W, 16, beat width; multiple of 8, 8..64
- POLY, 16'h1021, generator in normal notation (implicit x^CRC_W term omitted); applied reflected, LSB-first
- INIT, 16'hFFFF, CRC register value loaded at start of frame
- XOROUT, 16'h0000, XOR applied to the register to form crc_dout
- clk_sys  in  1  system clock
- rst_sys  in  1  reset; asynchronous, active-low
- crc_sop  in  1  first beat of frame; qualified by crc_din_vld
- crc_eop  in  1  last beat of frame; qualified by crc_din_vld
- crc_din_vld  in  1  beat valid
- crc_din  in  DATA_W  beat data; byte lane 0 = bits [7:0], processed first
- crc_be  in  DATA_W/8  byte enables; all-ones except on the eop beat
- crc_chk_en  in  1  sampled on the eop beat; 1 = compare mode
- crc_ref  in  CRC_W  expected CRC; sampled on the eop beat
- crc_dout  out  CRC_W  final CRC (register ^ XOROUT) of the last completed frame
- crc_done  out  1  one-cycle pulse: crc_dout/crc_err updated
- crc_err  out  1  compare result (1 = mismatch); 0 when chk_en was 0
- crc_busy  out  1  frame in progress (state RUN)
- crc_seq_err  out  1  one-cycle pulse on a framing violation

## Operation
- State machine: IDLE, RUN.
- IDLE + vld + sop + !eop: register <= f(INIT, beat); go to RUN.
- IDLE + vld + sop + eop: single-beat frame; result = f(INIT, beat); complete; stay in IDLE.
- IDLE + vld + !sop: beat dropped, seq_err pulse, stay in IDLE.
- RUN + vld + !sop + !eop: register <= f(register, beat).
- RUN + vld + eop: complete with f(register, beat); go to IDLE.
- RUN + vld + sop: previous frame abandoned, no done, seq_err pulse. The beat starts a new frame from INIT; if eop is also set, it completes as a single-beat frame.
- !vld: no state or register change in either state.
- f(): for each byte lane k = 0 up to DATA_W/8-1 with be[k]=1, process bits 0..7 LSB-first through the reflected LFSR. Disabled lanes are skipped.
- be rules:
  - be must be contiguous from lane 0. Non-contiguous or all-zero be on an eop beat: only the lowest contiguous run of set lanes is processed, and seq_err pulses.
  - be != all-ones on a non-eop beat: seq_err pulses and the beat is processed as all-ones.
- Completion:
  - crc_dout <= result ^ XOROUT.
  - crc_err <= chk_en & ((result ^ XOROUT) != crc_ref).
  - crc_done <= 1.
- crc_dout and crc_err hold until the next completion.
- Update logic is combinational unrolled across all lanes. There is no backpressure: one beat is accepted every cycle.

## Timing
- Reset values: crc_dout=0, crc_done=0, crc_err=0, crc_busy=0, crc_seq_err=0, state=IDLE, register=INIT.
- Latency: crc_done, crc_dout and crc_err are registered and appear the cycle after the eop beat.
- crc_busy is high from the cycle after a non-eop sop beat through the eop beat's cycle. It is low the cycle after eop.
- crc_seq_err asserts the cycle after the offending beat, for one cycle.
- Back-to-back frames: a sop beat in the cycle directly after an eop beat is legal. It produces no seq_err.
- Reset mid-frame: all state returns to reset values immediately and the partial frame is lost. The first beat after reset must carry sop.

## Test plan
- ASCII "123456789" as beats 0x3231, 0x3433, 0x3635, 0x3837, with sop on the first beat. Final beat 0x0039 with be=01 and eop. Defaults, chk_en=0 -> done pulse one cycle after eop, crc_dout=0x6F91, crc_err=0.
- Same frame with chk_en=1: crc_ref=0x6F91 gives crc_err=0; crc_ref=0x6F90 gives crc_err=1. Both give a done pulse.
- CRC_W=32, DATA_W=32, POLY=32'h04C11DB7, INIT=XOROUT=32'hFFFFFFFF. Beats 0x34333231, 0x38373635, then 0x00000039 with be=0001 and eop -> crc_dout=0xCBF43926.
- Single-beat frame with sop=eop=1, DATA_W=16, data 0x3231, be=11 -> done next cycle. crc_busy never asserts.
- Sequence errors:
  - vld without sop in IDLE -> seq_err pulse, no done.
  - sop mid-frame -> seq_err pulse, no done for the first frame. The second frame "123456789" still yields 0x6F91.
- Assert rst_sys low mid-frame, then send the full "123456789" frame -> outputs zero during reset, then 0x6F91.
